// File: rtl/framebuffer_pattern_gen_if.sv
// framebuffer_pattern_gen_if: push-button inputs and lane/sync outputs of the test-pattern source.
interface framebuffer_pattern_gen_if #(parameter int LANES = 30);
  logic color_button;
  logic mode_button;
  logic [LANES-1:0] data;
  logic data_valid;
  logic sync;
  logic [1:0] mode;
  modport master(input color_button, mode_button, output data, data_valid, sync, mode);
  modport slave(output color_button, mode_button, input data, data_valid, sync, mode);
endinterface

// File: rtl/framebuffer_pattern_gen.sv
// framebuffer_pattern_gen: framebuffer stand-in producing lane bits, valid and frame sync for the driver.
// Define FBPG_DEBOUNCE_EN to insert a DEBOUNCE_CYCLES debouncer after each button synchroniser.
module framebuffer_pattern_gen #(
  parameter int LANES = 30,
  parameter int SEGMENT_CYCLES = 513,
  parameter int BLANKING_CYCLES = 72,
  parameter int GROUP_LEN = 48,
  parameter int MUX_COUNT = 8
`ifdef FBPG_DEBOUNCE_EN
  , parameter int DEBOUNCE_CYCLES = 65536
`endif
) (
  input logic clk_33,
  input logic rst,
  framebuffer_pattern_gen_if.master bus
);
  localparam int SW = $clog2(SEGMENT_CYCLES);
  localparam int MW = MUX_COUNT > 1 ? $clog2(MUX_COUNT) : 1;
  localparam int GW = $clog2(GROUP_LEN + 1);
  localparam int PW = LANES > 1 ? $clog2(LANES) : 1;
  logic [SW-1:0] seg_cnt;
  logic [MW-1:0] mux_cnt;
  logic [GW-1:0] grp_cnt;
  logic [PW-1:0] walk_pos;
  logic [1:0] color_sel, mode_r, pend, btn_s1, btn_s2, btn_edge;
  logic blanking, seg_last, boundary, valid_nxt, hit;
  logic [LANES-1:0] data_nxt;
  int color_bit, led_idx;
  assign blanking = seg_cnt < SW'(BLANKING_CYCLES);
  assign seg_last = seg_cnt == SW'(SEGMENT_CYCLES - 1);
  assign boundary = seg_last && mux_cnt == MW'(MUX_COUNT - 1);
  assign bus.mode = mode_r;
  always_comb begin
    color_bit = int'(grp_cnt) % 3;
    led_idx = int'(grp_cnt) / 3;
    valid_nxt = !blanking && grp_cnt < GW'(GROUP_LEN);
    hit = mode_r == 2'd1 ? color_bit == (led_idx % 3 + int'(color_sel)) % 3
        : mode_r == 2'd3 ? color_bit == int'(color_sel) && led_idx == int'(mux_cnt) % (GROUP_LEN / 3)
        : color_bit == int'(color_sel);
    data_nxt = !(valid_nxt && hit) ? '0 : mode_r == 2'd2 ? LANES'(1) << walk_pos : '1;
  end
  always_ff @(posedge clk_33 or posedge rst)
    if (rst) {btn_s2, btn_s1} <= '0;
    else {btn_s2, btn_s1} <= {btn_s1, bus.mode_button, bus.color_button};
`ifdef FBPG_DEBOUNCE_EN
  localparam int DW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  // The accepted level only flips after DEBOUNCE_CYCLES consecutive differing samples.
  for (genvar i = 0; i < 2; i++) begin : g_deb
    logic [DW-1:0] cnt;
    logic lvl, done;
    assign done = cnt == DW'(DEBOUNCE_CYCLES - 1);
    assign btn_edge[i] = btn_s2[i] && !lvl && done;
    always_ff @(posedge clk_33 or posedge rst)
      if (rst) begin
        cnt <= '0;
        lvl <= 1'b0;
      end else if (btn_s2[i] == lvl || done) begin
        cnt <= '0;
        lvl <= btn_s2[i];
      end else cnt <= cnt + 1'b1;
  end
`else
  logic [1:0] btn_s3;
  always_ff @(posedge clk_33 or posedge rst)
    if (rst) btn_s3 <= '0;
    else btn_s3 <= btn_s2;
  assign btn_edge = btn_s2 & ~btn_s3;
`endif
  // Settings only move at the sync cycle; an edge arriving in that same cycle waits for the next frame.
  always_ff @(posedge clk_33 or posedge rst)
    if (rst) begin
      seg_cnt <= '0;
      mux_cnt <= '0;
      grp_cnt <= '0;
      bus.data <= '0;
      bus.data_valid <= 1'b0;
      bus.sync <= 1'b0;
      mode_r <= '0;
      color_sel <= '0;
      walk_pos <= '0;
      pend <= '0;
    end else begin
      seg_cnt <= seg_last ? '0 : seg_cnt + 1'b1;
      if (seg_last) mux_cnt <= mux_cnt == MW'(MUX_COUNT - 1) ? '0 : mux_cnt + 1'b1;
      grp_cnt <= blanking || seg_last || grp_cnt == GW'(GROUP_LEN) ? '0 : grp_cnt + 1'b1;
      bus.data <= data_nxt;
      bus.data_valid <= valid_nxt;
      bus.sync <= boundary;
      pend <= boundary ? btn_edge : pend | btn_edge;
      if (boundary) begin
        if (pend[0]) color_sel <= color_sel == 2'd2 ? 2'd0 : color_sel + 2'd1;
        if (pend[1]) mode_r <= mode_r + 2'd1;
        walk_pos <= walk_pos == PW'(LANES - 1) ? '0 : walk_pos + 1'b1;
      end
    end
endmodule

// File: tb/tb_framebuffer_pattern_gen.sv
// tb_framebuffer_pattern_gen: random button presses checked cycle by cycle against a frame-level model.
// MUX_COUNT is reduced to 2 so the walking bit can wrap within a short run.
module tb_framebuffer_pattern_gen;
  localparam int LANES = 30, SEG = 513, BLANK = 72, GLEN = 48, MUX = 2, N = SEG * MUX;
`ifdef FBPG_DEBOUNCE_EN
  localparam int DEB = 16, LAT = DEB + 2, PLEN = DEB;
`else
  localparam int LAT = 3, PLEN = 1;
`endif
  logic clk_33 = 1'b0;
  logic rst = 1'b1;
  framebuffer_pattern_gen_if #(.LANES(LANES)) bus();
  framebuffer_pattern_gen #(
    .LANES(LANES), .SEGMENT_CYCLES(SEG), .BLANKING_CYCLES(BLANK), .GROUP_LEN(GLEN), .MUX_COUNT(MUX)
`ifdef FBPG_DEBOUNCE_EN
    , .DEBOUNCE_CYCLES(DEB)
`endif
  ) dut (.clk_33(clk_33), .rst(rst), .bus(bus));
  always #5 clk_33 = ~clk_33;
  int checks = 0, failures = 0;
  int e = 0, m_mode = 0, m_color = 0, m_walk = 0, d_mode = 0, d_color = 0, d_walk = 0;
  int cap_c[$], cap_m[$];
  bit sc, sm;
  logic [LANES-1:0] ed;
  logic ev, es;
  logic [1:0] em;
  // e counts clock edges since reset release; a press counts for the frame whose boundary comes after its capture edge.
  always @(posedge clk_33) begin
    if (rst) begin
      e = 0; m_mode = 0; m_color = 0; m_walk = 0; d_mode = 0; d_color = 0; d_walk = 0;
      cap_c.delete(); cap_m.delete();
    end else begin
      e++;
      d_mode = m_mode; d_color = m_color; d_walk = m_walk;
      if (e % N == 0) begin
        sc = 0; sm = 0;
        while (cap_c.size() > 0 && cap_c[0] < e) begin void'(cap_c.pop_front()); sc = 1; end
        while (cap_m.size() > 0 && cap_m[0] < e) begin void'(cap_m.pop_front()); sm = 1; end
        if (sc) m_color = (m_color + 1) % 3;
        if (sm) m_mode = (m_mode + 1) % 4;
        m_walk = (m_walk + 1) % LANES;
      end
    end
  end
  function automatic void expect_out(output logic [LANES-1:0] d, output logic v, output logic s, output logic [1:0] m);
    int k, seg, mux, grp, cb, led;
    bit h;
    m = 2'(m_mode);
    d = '0; v = 1'b0; s = 1'b0;
    if (e == 0) return;
    k = e - 1;
    seg = k % SEG;
    mux = (k / SEG) % MUX;
    grp = (seg - BLANK) % (GLEN + 1);
    v = seg >= BLANK && grp < GLEN;
    s = k % N == N - 1;
    cb = grp % 3;
    led = grp / 3;
    case (d_mode)
      1: h = cb == (led % 3 + d_color) % 3;
      3: h = cb == d_color && led == mux % (GLEN / 3);
      default: h = cb == d_color;
    endcase
    if (v && h) d = d_mode == 2 ? LANES'(1) << d_walk : '1;
  endfunction
  task automatic press(input bit on_mode, input int len);
    @(posedge clk_33);
    #1;
`ifdef FBPG_DEBOUNCE_EN
    if (len >= DEB) begin
`else
    begin
`endif
      if (on_mode) cap_m.push_back(e + LAT);
      else cap_c.push_back(e + LAT);
    end
    if (on_mode) bus.mode_button = 1'b1;
    else bus.color_button = 1'b1;
    repeat (len) @(posedge clk_33);
    #1;
    bus.mode_button = 1'b0;
    bus.color_button = 1'b0;
    repeat (PLEN + 6) @(posedge clk_33);
  endtask
  task automatic test_reset();
    repeat (3) begin
      @(negedge clk_33);
      checks++;
      if ({bus.data, bus.data_valid, bus.sync, bus.mode} !== '0)
        $display("FAIL reset: got data=%h valid=%b sync=%b mode=%0d, expected all zero", bus.data, bus.data_valid, bus.sync, bus.mode);
      if ({bus.data, bus.data_valid, bus.sync, bus.mode} !== '0) failures++;
    end
    @(posedge clk_33);
    #1 rst = 1'b0;
  endtask
  task automatic test_timing();
    int first = -1, second = -1;
    repeat (2 * N + 20) begin
      @(negedge clk_33);
      expect_out(ed, ev, es, em);
      checks++;
      if ({bus.data, bus.data_valid, bus.sync, bus.mode} !== {ed, ev, es, em}) begin
        failures++;
        $display("FAIL timing e=%0d: got %h/%b/%b/%0d, expected %h/%b/%b/%0d", e, bus.data, bus.data_valid, bus.sync, bus.mode, ed, ev, es, em);
      end
      if (bus.sync === 1'b1) begin
        if (first < 0) first = e;
        else if (second < 0) second = e;
      end
    end
    checks++;
    if (first !== N) begin failures++; $display("FAIL first_sync: got edge %0d, expected %0d", first, N); end
    checks++;
    if (second !== 2 * N) begin failures++; $display("FAIL sync_period: got edge %0d, expected %0d", second, 2 * N); end
  endtask
  task automatic test_color();
    int b1 = (e / N + 1) * N;
    fork
      begin
        repeat ($urandom_range(0, 200)) @(posedge clk_33);
        press(1'b0, PLEN + $urandom_range(0, 3));
        repeat ($urandom_range(0, 200)) @(posedge clk_33);
        press(1'b0, PLEN + $urandom_range(0, 3));
      end
      while (e < b1 + SEG) begin
        @(negedge clk_33);
        expect_out(ed, ev, es, em);
        checks++;
        if ({bus.data, bus.data_valid, bus.sync, bus.mode} !== {ed, ev, es, em}) begin
          failures++;
          $display("FAIL color e=%0d: got %h/%b/%b/%0d, expected %h/%b/%b/%0d", e, bus.data, bus.data_valid, bus.sync, bus.mode, ed, ev, es, em);
        end
        if (e == b1 - SEG + BLANK + 1) begin
          checks++;
          if (bus.data !== {LANES{1'b1}}) begin failures++; $display("FAIL color_before_sync: got %h, expected all ones", bus.data); end
        end
        if (e == b1 + BLANK + 1) begin
          checks++;
          if (bus.data !== '0 || bus.data_valid !== 1'b1) begin failures++; $display("FAIL color_grp0: got %h valid=%b, expected 0 valid=1", bus.data, bus.data_valid); end
        end
        if (e == b1 + BLANK + 2) begin
          checks++;
          if (bus.data !== {LANES{1'b1}}) begin failures++; $display("FAIL color_grp1: got %h, expected all ones", bus.data); end
        end
      end
    join
  endtask
  task automatic test_boundary_edge();
    int b = (e / N + 2) * N;
    fork
      begin
        while (e < b - LAT - 1) begin @(posedge clk_33); #1; end
        press(1'b0, PLEN + $urandom_range(0, 3));
      end
      while (e < b + N + SEG) begin
        @(negedge clk_33);
        expect_out(ed, ev, es, em);
        checks++;
        if ({bus.data, bus.data_valid, bus.sync, bus.mode} !== {ed, ev, es, em}) begin
          failures++;
          $display("FAIL boundary_edge e=%0d: got %h/%b/%b/%0d, expected %h/%b/%b/%0d", e, bus.data, bus.data_valid, bus.sync, bus.mode, ed, ev, es, em);
        end
      end
    join
  endtask
  task automatic test_mode_walk();
    int b1 = (e / N + 1) * N;
    fork
      begin
        repeat ($urandom_range(0, 400)) @(posedge clk_33);
        press(1'b1, PLEN + $urandom_range(0, 3));
        while (e < b1 + 10) begin @(posedge clk_33); #1; end
        repeat ($urandom_range(0, 400)) @(posedge clk_33);
        press(1'b1, PLEN + $urandom_range(0, 3));
      end
      while (e < b1 + 31 * N + SEG) begin
        @(negedge clk_33);
        expect_out(ed, ev, es, em);
        checks++;
        if ({bus.data, bus.data_valid, bus.sync, bus.mode} !== {ed, ev, es, em}) begin
          failures++;
          $display("FAIL walk e=%0d: got %h/%b/%b/%0d, expected %h/%b/%b/%0d", e, bus.data, bus.data_valid, bus.sync, bus.mode, ed, ev, es, em);
        end
      end
    join
    checks++;
    if (bus.mode !== 2'd2) begin failures++; $display("FAIL walk_mode: got %0d, expected 2", bus.mode); end
  endtask
  task automatic test_pattern(input int frames);
    int b1 = (e / N + 1) * N;
    fork
      begin
        repeat ($urandom_range(0, 300)) @(posedge clk_33);
        press(1'b1, PLEN + $urandom_range(0, 3));
        for (int f = 0; f < frames; f++) begin
          while (e < b1 + f * N + 10) begin @(posedge clk_33); #1; end
          repeat ($urandom_range(0, 600)) @(posedge clk_33);
          if ($urandom_range(0, 3) != 0) press(1'b0, PLEN + $urandom_range(0, 3));
        end
      end
      while (e < b1 + frames * N + SEG) begin
        @(negedge clk_33);
        expect_out(ed, ev, es, em);
        checks++;
        if ({bus.data, bus.data_valid, bus.sync, bus.mode} !== {ed, ev, es, em}) begin
          failures++;
          $display("FAIL pattern e=%0d: got %h/%b/%b/%0d, expected %h/%b/%b/%0d", e, bus.data, bus.data_valid, bus.sync, bus.mode, ed, ev, es, em);
        end
      end
    join
  endtask
  task automatic test_reset_mid();
    int first = -1;
    while (e % SEG != SEG / 2 + $urandom_range(0, 20)) begin @(posedge clk_33); #1; end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.data, bus.data_valid, bus.sync, bus.mode} !== '0) begin
      failures++;
      $display("FAIL reset_mid: got data=%h valid=%b sync=%b mode=%0d, expected all zero", bus.data, bus.data_valid, bus.sync, bus.mode);
    end
    @(posedge clk_33);
    repeat (2) begin
      @(negedge clk_33);
      expect_out(ed, ev, es, em);
      checks++;
      if ({bus.data, bus.data_valid, bus.sync, bus.mode} !== {ed, ev, es, em}) begin
        failures++;
        $display("FAIL reset_hold e=%0d: got %h/%b/%b/%0d, expected %h/%b/%b/%0d", e, bus.data, bus.data_valid, bus.sync, bus.mode, ed, ev, es, em);
      end
    end
    @(posedge clk_33);
    #1 rst = 1'b0;
    repeat (N + SEG) begin
      @(negedge clk_33);
      expect_out(ed, ev, es, em);
      checks++;
      if ({bus.data, bus.data_valid, bus.sync, bus.mode} !== {ed, ev, es, em}) begin
        failures++;
        $display("FAIL reset_restart e=%0d: got %h/%b/%b/%0d, expected %h/%b/%b/%0d", e, bus.data, bus.data_valid, bus.sync, bus.mode, ed, ev, es, em);
      end
      if (bus.sync === 1'b1 && first < 0) first = e;
    end
    checks++;
    if (first !== N) begin failures++; $display("FAIL reset_sync: got edge %0d, expected %0d", first, N); end
  endtask
`ifdef FBPG_DEBOUNCE_EN
  task automatic test_debounce();
    int b1 = (e / N + 1) * N;
    fork
      begin
        repeat ($urandom_range(0, 100)) @(posedge clk_33);
        press(1'b0, 10);
        repeat (DEB) @(posedge clk_33);
        press(1'b0, 20);
      end
      while (e < b1 + N + SEG) begin
        @(negedge clk_33);
        expect_out(ed, ev, es, em);
        checks++;
        if ({bus.data, bus.data_valid, bus.sync, bus.mode} !== {ed, ev, es, em}) begin
          failures++;
          $display("FAIL debounce e=%0d: got %h/%b/%b/%0d, expected %h/%b/%b/%0d", e, bus.data, bus.data_valid, bus.sync, bus.mode, ed, ev, es, em);
        end
      end
    join
  endtask
`endif
  initial begin
    bus.color_button = 1'b0;
    bus.mode_button = 1'b0;
    test_reset();
    test_timing();
    test_color();
    test_boundary_edge();
    test_mode_walk();
    test_pattern(3);
    test_reset_mid();
    test_pattern(3);
`ifdef FBPG_DEBOUNCE_EN
    test_debounce();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
